// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the single-bus datapath.
// master = sequencer (drives strobes), slave = datapath / bench side.
interface control_sequencer_if;
  // start is a level request: it is sampled only while the sequencer is in
  // IDLE and is ignored in every other state; there is no ready/ack path.
  logic [31:0] IR;
  logic        start;
  logic        MemRdy;

  logic        PCout, Zlowout, Zhighout, MDRout;
  logic        MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin;
  logic        IncPC, read;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  ALU;
  logic        run;
  logic        illegal;
  logic [15:0] inst_count;
  logic [2:0]  state;

  modport master (
    input  IR, start, MemRdy,
    output PCout, Zlowout, Zhighout, MDRout,
    output MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin,
    output IncPC, read, Gra, Grb, Grc, Rin, Rout,
    output ALU, run, illegal, inst_count, state
  );

  modport slave (
    output IR, start, MemRdy,
    input  PCout, Zlowout, Zhighout, MDRout,
    input  MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin,
    input  IncPC, read, Gra, Grb, Grc, Rin, Rout,
    input  ALU, run, illegal, inst_count, state
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T6, instruction count.
// Optional MEM_WAIT_EN: T1 holds until MemRdy=1 at a rising edge.
module control_sequencer (
  input  logic               clock,
  input  logic               clear,
  control_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_T0 = 3'd1, S_T1 = 3'd2, S_T2 = 3'd3,
    S_T3   = 3'd4, S_T4 = 3'd5, S_T5 = 3'd6, S_T6 = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [4:0] op;
  logic       is_3r, is_un, is_md, is_nop, is_halt, is_ill;
  logic       count_inc;
  logic       illegal_q;
  logic [15:0] count_q;
  logic       unused_fields;

  assign op = bus.IR[31:27];
  // Register fields are routed by the datapath via Gra/Grb/Grc, not here.
  assign unused_fields = ^{bus.IR[26:0], bus.MemRdy};

  always_comb begin
    is_3r   = 1'b0;
    is_un   = 1'b0;
    is_md   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    is_ill  = 1'b0;
    case (op)
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000: is_3r   = 1'b1;
      5'b10001, 5'b10010:           is_un   = 1'b1;
      5'b01111, 5'b10000:           is_md   = 1'b1;
      5'b11011:                     is_nop  = 1'b1;
      5'b11100:                     is_halt = 1'b1;
      default:                      is_ill  = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (bus.start) next_state = S_T0;
      S_T0:   next_state = S_T1;
`ifdef MEM_WAIT_EN
      S_T1:   next_state = bus.MemRdy ? S_T2 : S_T1;
`else
      S_T1:   next_state = S_T2;
`endif
      S_T2:   next_state = S_T3;
      S_T3: begin
        if (is_nop)                next_state = S_T0;
        else if (is_halt || is_ill) next_state = S_IDLE;
        else                       next_state = S_T4;
      end
      S_T4:   next_state = S_T5;
      S_T5:   next_state = is_md ? S_T6 : S_T0;
      S_T6:   next_state = S_T0;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.MDRout = 1'b0;
    bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
    bus.Yin = 1'b0; bus.Zlowin = 1'b0; bus.Zhighin = 1'b0;
    bus.LOin = 1'b0; bus.HIin = 1'b0;
    bus.IncPC = 1'b0; bus.read = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.ALU = 5'b00000;
    case (state)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        if (is_3r || is_un) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_md) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end
      end
      S_T4: begin
        bus.Rout   = 1'b1;
        bus.Zlowin = 1'b1;
        bus.ALU    = op;
        bus.Grc    = is_3r;
        bus.Grb    = is_un || is_md;
        bus.Zhighin = is_md;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        bus.LOin    = is_md;
        bus.Gra     = !is_md;
        bus.Rin     = !is_md;
      end
      S_T6: begin
        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
      end
      default: ;
    endcase
  end

  // Completed instructions: NOP/HALT retire in T3, ALU/unary in T5, MUL/DIV in T6.
  assign count_inc = ((state == S_T3) && (is_nop || is_halt)) ||
                     ((state == S_T5) && !is_md) ||
                     (state == S_T6);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      illegal_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      if ((state == S_IDLE) && bus.start)
        illegal_q <= 1'b0;
      else if ((state == S_T3) && is_ill)
        illegal_q <= 1'b1;
      if (count_inc)
        count_q <= count_q + 16'd1;
    end
  end

  assign bus.run        = (state != S_IDLE);
  assign bus.illegal    = illegal_q;
  assign bus.inst_count = count_q;
  assign bus.state      = state;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit single-bus datapath. It steps the fetch cycles T0–T2, decodes the instruction register, and drives the execute steps T3–T6 for register ALU, MUL and DIV instructions. It owns every bus-driver enable, every register-load strobe and the ALU select, replacing hand-sequenced control with one Moore state machine. It also counts completed instructions and stops on HALT or on an illegal opcode.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous, active-high.
- IR  in  32  datapath instruction register. Fields: op = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- start  in  1  leaves IDLE and begins fetch.
- MemRdy  in  1  memory read complete; used only with MEM_WAIT_EN.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus-driver enables.
- MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin  out  1 each  register load strobes.
- IncPC, read  out  1 each  PC increment; memory read.
- Gra, Grb, Grc, Rin, Rout  out  1 each  general-register field select and in/out enables.
- ALU  out  5  ALU operation select.
- run  out  1  high in any state other than IDLE.
- illegal  out  1  sticky flag: an illegal opcode was decoded.
- inst_count  out  16  count of completed instructions.

## Operation
- Opcodes:
  - 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 SHR, 01000 SHL (three-register)
  - 10001 NEG, 10010 NOT (unary)
  - 01111 MUL, 10000 DIV
  - 11011 NOP, 11100 HALT
  - Any other opcode is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Outputs decode only from the registered state and IR; no strobe is asserted outside the states listed below.
- IDLE: all strobes 0. `start`=1 moves to T0 and clears `illegal`.
- T0: PCout, MARin, IncPC, Zlowin.
- T1: Zlowout, PCin, read, MDRin.
- T2: MDRout, IRin.
- T3, by opcode:
  - Three-register or unary: Grb, Rout, Yin.
  - MUL/DIV: Gra, Rout, Yin.
  - NOP: no strobes; next state T0.
  - HALT: no strobes; next state IDLE.
  - Illegal: set `illegal`; next state IDLE.
- T4, by opcode:
  - Three-register: Grc, Rout, ALU=op, Zlowin.
  - Unary: Grb, Rout, ALU=op, Zlowin.
  - MUL/DIV: Grb, Rout, ALU=op, Zlowin, Zhighin.
- T5:
  - ALU and unary: Zlowout, Gra, Rin; next state T0.
  - MUL/DIV: Zlowout, LOin.
- T6 (MUL/DIV only): Zhighout, HIin; next state T0.
- ALU output is 5'b00000 in every state except T4.
- inst_count increments by 1 on each transition into T0 from T3 (NOP), T5 or T6. It also increments on HALT's T3→IDLE transition. It does not increment on illegal opcodes. It wraps from 16'hFFFF to 0.
- `start` is ignored outside IDLE.
- `clear` at any time, mid-instruction included, takes effect immediately: state=IDLE, all strobes 0, run=0, illegal=0, inst_count=0.

## Timing
- Every strobe is high for exactly one full clock period per listed state. Strobes change only after a rising edge, never mid-cycle.
- Latency, counted in cycles from the first T0:
  - Fetch: 3.
  - NOP: 4.
  - ALU or unary: 6.
  - MUL/DIV: 7.
  - HALT/illegal: 4, then IDLE.
- IR is sampled from T3 onward. It stays stable because IRin occurs only in T2.
- The `start` edge that leaves IDLE makes T0 active in the next cycle.
- Back-to-back instructions need no idle cycles: the last execute step is followed directly by T0.

## Configuration
- MEM_WAIT_EN defined: T1 holds while MemRdy=0 at the rising edge. Zlowout, PCin, read and MDRin stay asserted through the hold. The machine moves to T2 on the first edge with MemRdy=1, so each wait cycle adds 1 cycle of latency.
- MEM_WAIT_EN undefined: MemRdy is ignored and T1 always lasts one cycle.

## Test plan
- ADD: clear, start, IR=0x18918000 (ADD R1,R2,R3) → T3 Grb+Rout+Yin; T4 Grc+Rout+Zlowin with ALU=00011; T5 Zlowout+Gra+Rin; back in T0 on cycle 7; inst_count=1.
- MUL: IR=0x7B380000 (MUL R6,R7) → T4 asserts Zlowin and Zhighin with ALU=01111; T5 Zlowout+LOin; T6 Zhighout+HIin; 7-cycle instruction.
- NOP then HALT: IR=0xD8000000, then IR=0xE0000000 → NOP returns to T0 after 4 cycles; HALT reaches IDLE with run=0; inst_count=2.
- Illegal: IR=0xF8000000 → IDLE, illegal=1, inst_count unchanged. A subsequent `start` clears `illegal`.
- Reset mid-instruction: assert clear halfway through T4 of a MUL → all strobes 0 and state IDLE before the next edge; inst_count=0.
- Wait states (MEM_WAIT_EN): hold MemRdy=0 for 3 cycles in T1 → read and MDRin high for 4 cycles; ADD total latency 9 cycles.
